// File: rtl/fabric_mem_slave_pkg.sv
`include "INIT_VARIABLE.v"
`default_nettype none
// +--------------------------------------------------------------------------+
// | fabric_mem_slave_pkg : shared types and helpers for the fabric slave      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fabric_mem_slave_pkg;

    localparam int SEG_W = `LEN_SEGMENT;

    typedef enum logic [3:0] {
        S_IDLE    = `FMS_IDLE,
        S_ACK     = `FMS_ACK,
        S_WAIT_OP = `FMS_WAIT_OP,
        S_WRITE   = `FMS_WRITE,
        S_READ    = `FMS_READ
    } fms_state_e;

    // Element [3] is word3 (SA_D3) down to element [0], word0 (IP_D0).
    typedef logic [3:0][SEG_W-1:0] fms_line_t;

    // A case match never matches Z/X, so floating strobes read as deasserted.
    function automatic logic is_high(input logic b);
        case (b)
            1'b1:    is_high = 1'b1;
            default: is_high = 1'b0;
        endcase
    endfunction

    function automatic logic is_low(input logic b);
        case (b)
            1'b0:    is_low = 1'b1;
            default: is_low = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_mem_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fabric_mem_slave_if : fabric strobes and busy/acknowledge handshake       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface fabric_mem_slave_if;
    logic ADDRFD;
    logic WRITEFD;
    logic READFD;
    logic BUSY_line_MASTER;
    logic BUSY_line_SLAVE;
    logic ERR;

    modport master (
        output ADDRFD, WRITEFD, READFD, BUSY_line_MASTER,
        input  BUSY_line_SLAVE, ERR
    );

    modport slave (
        input  ADDRFD, WRITEFD, READFD, BUSY_line_MASTER,
        output BUSY_line_SLAVE, ERR
    );
endinterface
`default_nettype wire

// File: rtl/INIT_VARIABLE.v
// Shared fabric definitions: segment width and FSM state encodings.
`ifndef INIT_VARIABLE_V
`define INIT_VARIABLE_V

`define LEN_SEGMENT 8

`define FMS_IDLE    4'd0
`define FMS_ACK     4'd1
`define FMS_WAIT_OP 4'd2
`define FMS_WRITE   4'd3
`define FMS_READ    4'd4

`endif

// File: rtl/fabric_mem_slave_line_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fms_line_ram : 2**ADDR_W lines of four words, 1 sync write, 1 comb read   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fms_line_ram
    import fabric_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  wire                   CLK_B,
    input  wire                   wr_en_i,
    input  wire [ADDR_W-1:0]      wr_addr_i,
    input  wire fms_line_t        wr_line_i,
    input  wire [ADDR_W-1:0]      rd_addr_i,
    output fms_line_t             rd_line_o
);
    fms_line_t mem_q [2**ADDR_W];

    always_ff @(posedge CLK_B) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_line_i;
        end
    end

    assign rd_line_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fabric_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fabric_mem_slave : fabric memory slave, address/ack/data-phase protocol   |
// | Optional WAIT_OP timeout with sticky ERR: define FMS_TIMEOUT_EN. Rev 1.0  |
// +--------------------------------------------------------------------------+
module fabric_mem_slave
    import fabric_mem_slave_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  wire                   CLK_B,
    input  wire                   RESET,
    fabric_mem_slave_if.slave     bus,
    inout  wire [SEG_W-1:0]       SA_D3,
    inout  wire [SEG_W-1:0]       SB_D2,
    inout  wire [SEG_W-1:0]       SC_D1,
    inout  wire [SEG_W-1:0]       IP_D0
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fabric_mem_slave: TIMEOUT must be at least 1");
    end

    fms_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              w_addr_req;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_master_rel;
    logic              w_timeout;
    logic              w_wr_en;
    logic              w_drive;
    logic [2*SEG_W-1:0] w_addr_cat;
    logic              w_unused_addr;
    fms_line_t         w_wr_line;
    fms_line_t         w_rd_line;

    assign w_addr_req   = is_high(bus.ADDRFD);
    assign w_wr_req     = is_high(bus.WRITEFD);
    assign w_rd_req     = is_high(bus.READFD);
    assign w_master_rel = !is_low(bus.BUSY_line_MASTER);

    // Only the low ADDR_W bits of {SC,IP} select a line; the rest is don't-care.
    assign w_addr_cat    = {SC_D1, IP_D0};
    assign w_unused_addr = ^w_addr_cat;
    assign w_wr_line     = {SA_D3, SB_D2, SC_D1, IP_D0};

`ifdef FMS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT_OP) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign w_timeout = (state_q == S_WAIT_OP) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            err_q <= 1'b0;
        end else if (w_timeout && !w_wr_req && !w_rd_req) begin
            err_q <= 1'b1;
        end
    end

    assign bus.ERR = err_q;
`else
    assign w_timeout = 1'b0;
    assign bus.ERR   = 1'b0;
`endif

    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        w_wr_en = 1'b0;
        w_drive = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_addr_req) begin
                    state_d = S_ACK;
                    idx_d   = w_addr_cat[ADDR_W-1:0];
                end
            end
            S_ACK: begin
                state_d = S_WAIT_OP;
            end
            S_WAIT_OP: begin
                if (w_wr_req) begin
                    state_d = S_WRITE;
                end else if (w_rd_req) begin
                    state_d = S_READ;
                end else if (w_master_rel || w_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                w_wr_en = 1'b1;
                state_d = S_IDLE;
            end
            S_READ: begin
                // Drive gated by the live strobe so the bus floats the cycle it drops.
                if (w_rd_req) begin
                    w_drive = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.BUSY_line_SLAVE = (state_q != S_IDLE);

    assign SA_D3 = w_drive ? w_rd_line[3] : {SEG_W{1'bz}};
    assign SB_D2 = w_drive ? w_rd_line[2] : {SEG_W{1'bz}};
    assign SC_D1 = w_drive ? w_rd_line[1] : {SEG_W{1'bz}};
    assign IP_D0 = w_drive ? w_rd_line[0] : {SEG_W{1'bz}};

    fms_line_ram #(
        .ADDR_W    (ADDR_W)
    ) u_line_ram (
        .CLK_B     (CLK_B),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (idx_q),
        .wr_line_i (w_wr_line),
        .rd_addr_i (idx_q),
        .rd_line_o (w_rd_line)
    );

endmodule
`default_nettype wire

// File: tb/tb_fabric_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fabric_mem_slave : directed self-checking bench for fabric_mem_slave   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fabric_mem_slave;
    import fabric_mem_slave_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic CLK_B = 1'b0;
    logic RESET = 1'b0;

    fabric_mem_slave_if bus();

    logic             drv;
    logic [SEG_W-1:0] d3, d2, d1, d0;
    wire  [SEG_W-1:0] SA_D3, SB_D2, SC_D1, IP_D0;

    assign SA_D3 = drv ? d3 : {SEG_W{1'bz}};
    assign SB_D2 = drv ? d2 : {SEG_W{1'bz}};
    assign SC_D1 = drv ? d1 : {SEG_W{1'bz}};
    assign IP_D0 = drv ? d0 : {SEG_W{1'bz}};

    int total = 0;
    int bad   = 0;

    logic [31:0] seen;

    fabric_mem_slave #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK_B (CLK_B),
        .RESET (RESET),
        .bus   (bus),
        .SA_D3 (SA_D3),
        .SB_D2 (SB_D2),
        .SC_D1 (SC_D1),
        .IP_D0 (IP_D0)
    );

    always #5 CLK_B = ~CLK_B;

    // A floating bus reads Z on a four-state simulator and 0 on a two-state one.
    function automatic logic undriven(input logic [31:0] v);
        return (v === 32'h0) || (v === {32{1'bz}});
    endfunction

    task automatic hold_bus(input logic [31:0] v);
        drv = 1'b1;
        {d3, d2, d1, d0} = v;
    endtask

    task automatic do_address(input logic [7:0] ip);
        hold_bus({8'hFF, 8'hFF, 8'h00, ip});
        bus.BUSY_line_MASTER = 1'b0;
        bus.ADDRFD = 1'b1;
        @(posedge CLK_B); #1;
        bus.ADDRFD = 1'b0;
        drv = 1'b0;
        @(posedge CLK_B); #1;
    endtask

    task automatic write_line(input logic [7:0] ip, input logic [31:0] data);
        do_address(ip);
        hold_bus(data);
        bus.WRITEFD = 1'b1;
        @(posedge CLK_B); #1;
        bus.WRITEFD = 1'b0;
        @(posedge CLK_B); #1;
        drv = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
    endtask

    task automatic read_line(input logic [7:0] ip, output logic [31:0] got);
        do_address(ip);
        bus.READFD = 1'b1;
        @(posedge CLK_B); #1;
        got = {SA_D3, SB_D2, SC_D1, IP_D0};
        bus.READFD = 1'b0;
        @(posedge CLK_B); #1;
        bus.BUSY_line_MASTER = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK_B);
        #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.BUSY_line_SLAVE); end
        total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.ERR); end
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (!undriven(seen)) begin bad++; $display("FAIL reset_bus got=%h want=Z", seen); end
        RESET = 1'b1;
        @(posedge CLK_B); #1;
    endtask

    task automatic test_write();
        hold_bus({8'hFF, 8'hFF, 8'h00, 8'h03});
        bus.BUSY_line_MASTER = 1'b0;
        bus.ADDRFD = 1'b1;
        #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL write_busy_pre got=%b want=0", bus.BUSY_line_SLAVE); end
        @(posedge CLK_B); #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b1) begin bad++; $display("FAIL write_busy_rise got=%b want=1", bus.BUSY_line_SLAVE); end
        bus.ADDRFD = 1'b0;
        drv = 1'b0;
        @(posedge CLK_B); #1;
        hold_bus(32'h0A0B0C0D);
        bus.WRITEFD = 1'b1;
        @(posedge CLK_B); #1;
        bus.WRITEFD = 1'b0;
        @(posedge CLK_B); #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL write_idle got=%b want=0", bus.BUSY_line_SLAVE); end
        drv = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
    endtask

    task automatic test_read_burst();
        do_address(8'h03);
        bus.READFD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK_B); #1;
            seen = {SA_D3, SB_D2, SC_D1, IP_D0};
            total++; if (seen !== 32'h0A0B0C0D) begin bad++; $display("FAIL read_cycle%0d got=%h want=0a0b0c0d", i, seen); end
        end
        bus.READFD = 1'b0;
        #1;
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (!undriven(seen)) begin bad++; $display("FAIL read_release got=%h want=Z", seen); end
        @(posedge CLK_B); #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL read_idle got=%b want=0", bus.BUSY_line_SLAVE); end
        bus.BUSY_line_MASTER = 1'b1;
    endtask

    task automatic test_reset_in_read();
        do_address(8'h03);
        bus.READFD = 1'b1;
        @(posedge CLK_B); #1;
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (seen !== 32'h0A0B0C0D) begin bad++; $display("FAIL rstread_pre got=%h want=0a0b0c0d", seen); end
        #1;
        RESET = 1'b0;
        #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL rstread_busy got=%b want=0", bus.BUSY_line_SLAVE); end
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (!undriven(seen)) begin bad++; $display("FAIL rstread_bus got=%h want=Z", seen); end
        bus.READFD = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
        @(posedge CLK_B); #1;
        RESET = 1'b1;
        @(posedge CLK_B); #1;
        read_line(8'h03, seen);
        total++; if (seen !== 32'h0A0B0C0D) begin bad++; $display("FAIL rstread_keep got=%h want=0a0b0c0d", seen); end
    endtask

    task automatic test_both_strobes();
        do_address(8'h07);
        hold_bus(32'h71727374);
        bus.WRITEFD = 1'b1;
        bus.READFD  = 1'b1;
        @(posedge CLK_B); #1;
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (seen !== 32'h71727374) begin bad++; $display("FAIL both_bus got=%h want=71727374", seen); end
        bus.WRITEFD = 1'b0;
        @(posedge CLK_B); #1;
        drv = 1'b0;
        #1;
        seen = {SA_D3, SB_D2, SC_D1, IP_D0};
        total++; if (!undriven(seen)) begin bad++; $display("FAIL both_float got=%h want=Z", seen); end
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL both_idle got=%b want=0", bus.BUSY_line_SLAVE); end
        bus.READFD = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
        @(posedge CLK_B); #1;
        read_line(8'h07, seen);
        total++; if (seen !== 32'h71727374) begin bad++; $display("FAIL both_stored got=%h want=71727374", seen); end
    endtask

    task automatic test_abort();
        do_address(8'h07);
        hold_bus(32'hEEEEEEEE);
        bus.BUSY_line_MASTER = 1'b1;
        @(posedge CLK_B); #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", bus.BUSY_line_SLAVE); end
        @(posedge CLK_B); #1;
        drv = 1'b0;
        read_line(8'h07, seen);
        total++; if (seen !== 32'h71727374) begin bad++; $display("FAIL abort_nowrite got=%h want=71727374", seen); end
    endtask

    task automatic test_addr_ignored();
        write_line(8'h05, 32'h51525354);
        do_address(8'h03);
        hold_bus({8'h00, 8'h00, 8'h00, 8'h05});
        bus.ADDRFD = 1'b1;
        @(posedge CLK_B); #1;
        bus.ADDRFD = 1'b0;
        total++; if (bus.BUSY_line_SLAVE !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", bus.BUSY_line_SLAVE); end
        hold_bus(32'h31323334);
        bus.WRITEFD = 1'b1;
        @(posedge CLK_B); #1;
        bus.WRITEFD = 1'b0;
        @(posedge CLK_B); #1;
        drv = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
        read_line(8'h03, seen);
        total++; if (seen !== 32'h31323334) begin bad++; $display("FAIL ign_line3 got=%h want=31323334", seen); end
        read_line(8'h05, seen);
        total++; if (seen !== 32'h51525354) begin bad++; $display("FAIL ign_line5 got=%h want=51525354", seen); end
    endtask

    task automatic test_timeout();
        do_address(8'h03);
        repeat (15) @(posedge CLK_B);
        #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b1) begin bad++; $display("FAIL tmo_early_busy got=%b want=1", bus.BUSY_line_SLAVE); end
        total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL tmo_early_err got=%b want=0", bus.ERR); end
        @(posedge CLK_B); #1;
`ifdef FMS_TIMEOUT_EN
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", bus.BUSY_line_SLAVE); end
        total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", bus.ERR); end
        bus.BUSY_line_MASTER = 1'b1;
        repeat (2) @(posedge CLK_B);
        #1;
        total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", bus.ERR); end
`else
        total++; if (bus.BUSY_line_SLAVE !== 1'b1) begin bad++; $display("FAIL tmo_wait_busy got=%b want=1", bus.BUSY_line_SLAVE); end
        total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL tmo_err got=%b want=0", bus.ERR); end
        bus.BUSY_line_MASTER = 1'b1;
        @(posedge CLK_B); #1;
        total++; if (bus.BUSY_line_SLAVE !== 1'b0) begin bad++; $display("FAIL tmo_abort got=%b want=0", bus.BUSY_line_SLAVE); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        drv = 1'b0;
        {d3, d2, d1, d0} = '0;
        bus.ADDRFD = 1'b0;
        bus.WRITEFD = 1'b0;
        bus.READFD = 1'b0;
        bus.BUSY_line_MASTER = 1'b1;
        test_reset();
        test_write();
        test_read_burst();
        test_reset_in_read();
        test_both_strobes();
        test_abort();
        test_addr_ignored();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
